pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Stall/flush sequencer for the 5-stage WISC pipeline; the companion to the forwarding logic.
- Covers the hazards forwarding cannot resolve: load-use, ID-stage branch register/flag dependencies, cache-miss freezes, taken-branch flushes and HALT drain.
- Drives write enables and flush controls of the PC and all pipeline registers, and keeps a saturating stall-cycle counter.

Parameters:
DRAIN_CYCLES, 3, cycles from HALT leaving ID until it has written back
CNT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
if_id_rs  in  4  source register Rs of instruction in ID
if_id_rt  in  4  source register Rt of instruction in ID
if_id_uses_rt  in  1  ID instruction reads Rt
if_id_store  in  1  ID instruction is SW
if_id_br_reg  in  1  ID instruction is BR (target in Rs)
if_id_br_flags  in  1  ID instruction is conditional B/BR (reads flags)
if_id_halt  in  1  ID instruction is HLT
id_ex_rd  in  4  destination of EX instruction
id_ex_write_reg  in  1  EX instruction writes register
id_ex_mem_read  in  1  EX instruction is LW
id_ex_sets_flags  in  1  EX instruction updates flags
ex_mem_rd  in  4  destination of MEM instruction
ex_mem_mem_read  in  1  MEM instruction is LW
branch_taken  in  1  branch resolved taken in ID
icache_miss  in  1  fetch slot invalid this cycle
dcache_miss  in  1  MEM-stage access not complete
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID enable
if_id_flush  out  1  load NOP into IF/ID
id_ex_flush  out  1  load NOP into ID/EX
ex_mem_write  out  1  EX/MEM enable
mem_wb_write  out  1  MEM/WB enable
halted  out  1  pipeline drained after HLT
stall_cycles  out  CNT_W  count of cycles with pc_write=0, saturating

Behaviour:
- States: RUN, STALL, DRAIN, HALTED. There is a 2-bit stall_cnt and a drain_cnt. Outputs are combinational from state and inputs.
- Reset: state RUN, stall_cnt=0, drain_cnt=0, stall_cycles=0, halted=0. After reset, outputs take their RUN idle values.
- RUN idle outputs: pc_write=1, if_id_write=1, ex_mem_write=1, mem_wb_write=1, both flushes 0.
- Register $0 never creates a hazard.
- Hazard depth n, evaluated in RUN only:
  - load-use: id_ex_mem_read and id_ex_rd matches if_id_rs, or matches if_id_rt with if_id_uses_rt -> n=1.
  - Exception: SW whose only match is Rt -> no stall (MEM-MEM forward covers it).
  - BR register dependency: if_id_br_reg and id_ex_write_reg and id_ex_rd==if_id_rs -> n=2 if id_ex_mem_read, else n=1.
  - BR on MEM-stage load: if_id_br_reg and ex_mem_mem_read and ex_mem_rd==if_id_rs -> n=1.
  - Flag dependency: if_id_br_flags and id_ex_sets_flags -> n=1.
  - If several rules match, n is the maximum.
- Stall cycle outputs: pc_write=0, if_id_write=0, id_ex_flush=1; back-end enables stay 1.
  - The detection cycle is stall cycle 1.
  - n=2: go to STALL with stall_cnt=1. STALL repeats the stall outputs, decrements, and returns to RUN when the count reaches 0.
  - Detection is not re-evaluated while in STALL.
- branch_taken is honoured only in RUN with n=0: pc_write=1, if_id_flush=1. It is ignored during a stall.
- icache_miss in RUN, with n=0 and no taken branch: pc_write=0, if_id_write=1, if_id_flush=1 (bubble). branch_taken overrides icache_miss.
- HLT: if_id_halt in RUN with n=0:
  - pc_write=0, if_id_flush=1, HLT advances.
  - Go to DRAIN with drain_cnt=DRAIN_CYCLES.
  - DRAIN: pc_write=0, if_id_flush=1, back end enabled, decrement; go to HALTED when drain_cnt reaches 1.
  - HALTED: all enables 0, halted=1. Exit is by rst only.
- dcache_miss (any state except HALTED) is a global freeze:
  - all enables 0, both flushes 0.
  - state, stall_cnt and drain_cnt hold.
  - This has highest priority.
- stall_cycles increments every cycle with pc_write=0 outside HALTED, freeze cycles included. It saturates at all-ones.
- rst mid-STALL or mid-DRAIN returns to RUN next cycle with counters cleared.

Test Plan:
- LW R3 in EX, ID = ADD R4,R3,R5 -> exactly 1 cycle: pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles 0->1.
- LW R3 in EX, ID = SW R3,0(R6) (Rt match only) -> no stall, pc_write stays 1.
- LW R2 in EX, ID = BR with Rs=R2 -> 2 consecutive stall cycles (RUN->STALL->RUN); branch_taken asserted during both is ignored; stall_cycles=2.
- ADD (sets flags) in EX, ID = conditional B, branch_taken=1 -> 1 stall cycle, then next cycle pc_write=1 and if_id_flush=1.
- dcache_miss held for 4 cycles in the middle of a 2-cycle BR stall -> all enables 0 for 4 cycles, stall_cnt held; the remaining stall cycle follows; stall_cycles=6.
- HLT in ID -> 3 DRAIN cycles, then halted=1 from the 5th cycle on; a later rst pulse gives halted=0, stall_cycles=0, RUN.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch-operand and flag stalls,
// taken-branch flush, I$/D$ miss freezes and HALT drain. Outputs are combinational from state and inputs.
module pipeline_hazard_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       if_id_rs,
  input  logic [3:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             if_id_store,
  input  logic             if_id_br_reg,
  input  logic             if_id_br_flags,
  input  logic             if_id_halt,
  input  logic [3:0]       id_ex_rd,
  input  logic             id_ex_write_reg,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_sets_flags,
  input  logic [3:0]       ex_mem_rd,
  input  logic             ex_mem_mem_read,
  input  logic             branch_taken,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_DRAIN, S_HALTED} state_t;

  state_t           state_q, state_d;
  logic [1:0]       stall_cnt_q, stall_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic ex_rs_hit, ex_rt_hit, lu_hit, br_ex_hit, br_mem_hit, flag_hit;
  logic need_stall, need_stall2;

  // R0 is hardwired to zero, so it never produces a dependency.
  always_comb begin
    ex_rs_hit   = (id_ex_rd != 4'd0) && (id_ex_rd == if_id_rs);
    ex_rt_hit   = (id_ex_rd != 4'd0) && if_id_uses_rt && (id_ex_rd == if_id_rt);
    // A store's data operand (Rt) is forwarded MEM->MEM, so it alone does not stall.
    lu_hit      = id_ex_mem_read && (ex_rs_hit || (ex_rt_hit && !if_id_store));
    br_ex_hit   = if_id_br_reg && id_ex_write_reg && ex_rs_hit;
    br_mem_hit  = if_id_br_reg && ex_mem_mem_read && (ex_mem_rd != 4'd0) && (ex_mem_rd == if_id_rs);
    flag_hit    = if_id_br_flags && id_ex_sets_flags;
    need_stall  = lu_hit || br_ex_hit || br_mem_hit || flag_hit;
    need_stall2 = br_ex_hit && id_ex_mem_read;
  end

  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    halted       = 1'b0;

    if (state_q == S_HALTED) begin
      halted = 1'b1;
    end else if (!dcache_miss) begin
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      unique case (state_q)
        S_RUN: begin
          if (need_stall) begin
            id_ex_flush = 1'b1;
            if (need_stall2) begin
              state_d     = S_STALL;
              stall_cnt_d = 2'd1;
            end
          end else if (branch_taken) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end else if (if_id_halt) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            state_d     = S_DRAIN;
            drain_cnt_d = DW'(DRAIN_CYCLES);
          end else if (icache_miss) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        S_STALL: begin
          id_ex_flush = 1'b1;
          stall_cnt_d = stall_cnt_q - 2'd1;
          if (stall_cnt_d == 2'd0) state_d = S_RUN;
        end
        S_DRAIN: begin
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          drain_cnt_d = drain_cnt_q - DW'(1);
          if (drain_cnt_q == DW'(1)) state_d = S_HALTED;
        end
        default: state_d = S_RUN;
      endcase
    end

    stall_cycles_d = stall_cycles_q;
    if ((state_q != S_HALTED) && !pc_write && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_RUN;
      stall_cnt_q    <= 2'd0;
      drain_cnt_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cnt_q    <= stall_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench: the driver queues hand-computed expectations, a monitor compares each cycle.
module tb_pipeline_hazard_controller;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
  logic if_id_uses_rt, if_id_store, if_id_br_reg, if_id_br_flags, if_id_halt;
  logic id_ex_write_reg, id_ex_mem_read, id_ex_sets_flags, ex_mem_mem_read;
  logic branch_taken, icache_miss, dcache_miss;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write, halted;
  logic [CW-1:0] stall_cycles;

  pipeline_hazard_controller #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .if_id_store(if_id_store), .if_id_br_reg(if_id_br_reg), .if_id_br_flags(if_id_br_flags),
    .if_id_halt(if_id_halt), .id_ex_rd(id_ex_rd), .id_ex_write_reg(id_ex_write_reg),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_sets_flags(id_ex_sets_flags),
    .ex_mem_rd(ex_mem_rd), .ex_mem_mem_read(ex_mem_mem_read),
    .branch_taken(branch_taken), .icache_miss(icache_miss), .dcache_miss(dcache_miss),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write, halted}
  localparam logic [6:0] V_RUN    = 7'b1100110;
  localparam logic [6:0] V_STALL  = 7'b0001110;
  localparam logic [6:0] V_BRFL   = 7'b1110110;
  localparam logic [6:0] V_BUBBLE = 7'b0110110;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_HALTED = 7'b0000001;

  logic [6+CW:0] exp_q[$];
  string         name_q[$];
  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [6+CW:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write,
            halted, stall_cycles};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 nm, a[6+CW:CW], a[CW-1:0], e[6+CW:CW], e[CW-1:0]);
      end
    end
  end

  task automatic idle();
    if_id_rs = 4'd0; if_id_rt = 4'd0; id_ex_rd = 4'd0; ex_mem_rd = 4'd0;
    if_id_uses_rt = 1'b0; if_id_store = 1'b0; if_id_br_reg = 1'b0; if_id_br_flags = 1'b0;
    if_id_halt = 1'b0; id_ex_write_reg = 1'b0; id_ex_mem_read = 1'b0; id_ex_sets_flags = 1'b0;
    ex_mem_mem_read = 1'b0; branch_taken = 1'b0; icache_miss = 1'b0; dcache_miss = 1'b0;
  endtask

  // Inputs are already set; queue the expectation and advance one cycle.
  task automatic cyc(input string nm, input logic [6:0] v, input int c);
    logic [CW-1:0] cc;
    cc = CW'(c);
    exp_q.push_back({v, cc});
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic rst_cyc();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic ex_load(input logic [3:0] rd);
    id_ex_mem_read = 1'b1; id_ex_write_reg = 1'b1; id_ex_rd = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    cyc("reset_idle", V_RUN, 0);

    ex_load(4'd3); if_id_rs = 4'd3; if_id_rt = 4'd5; if_id_uses_rt = 1'b1;
    cyc("loaduse_rs", V_STALL, 0);
    idle(); cyc("loaduse_after", V_RUN, 1);

    ex_load(4'd3); if_id_rs = 4'd6; if_id_rt = 4'd3; if_id_uses_rt = 1'b1; if_id_store = 1'b1;
    cyc("sw_rt_only", V_RUN, 1);
    idle(); ex_load(4'd0); if_id_rs = 4'd0; if_id_rt = 4'd0; if_id_uses_rt = 1'b1;
    cyc("r0_no_hazard", V_RUN, 1);
    idle(); ex_load(4'd7); if_id_rs = 4'd1; if_id_rt = 4'd7; if_id_uses_rt = 1'b1;
    cyc("loaduse_rt", V_STALL, 1);
    idle(); cyc("loaduse_rt_after", V_RUN, 2);
    ex_load(4'd7); if_id_rs = 4'd1; if_id_rt = 4'd7;
    cyc("rt_unused", V_RUN, 2);

    idle(); ex_load(4'd2); if_id_br_reg = 1'b1; if_id_rs = 4'd2; branch_taken = 1'b1;
    cyc("br_load_s1", V_STALL, 2);
    idle(); branch_taken = 1'b1;
    cyc("br_load_s2", V_STALL, 3);
    idle(); cyc("br_load_done", V_RUN, 4);

    id_ex_sets_flags = 1'b1; if_id_br_flags = 1'b1; branch_taken = 1'b1;
    cyc("flag_stall", V_STALL, 4);
    idle(); if_id_br_flags = 1'b1; branch_taken = 1'b1;
    cyc("flag_then_taken", V_BRFL, 5);
    idle(); cyc("flag_done", V_RUN, 5);

    if_id_br_reg = 1'b1; if_id_rs = 4'd9; ex_mem_mem_read = 1'b1; ex_mem_rd = 4'd9;
    cyc("br_mem_load", V_STALL, 5);
    idle(); cyc("br_mem_done", V_RUN, 6);

    id_ex_write_reg = 1'b1; id_ex_rd = 4'd4; if_id_br_reg = 1'b1; if_id_rs = 4'd4;
    cyc("br_alu_s1", V_STALL, 6);
    idle(); cyc("br_alu_one_only", V_RUN, 7);

    icache_miss = 1'b1;
    cyc("icache_bubble", V_BUBBLE, 7);
    branch_taken = 1'b1;
    cyc("taken_over_icache", V_BRFL, 8);
    idle(); cyc("icache_done", V_RUN, 8);

    ex_load(4'd2); if_id_br_reg = 1'b1; if_id_rs = 4'd2;
    cyc("frz_br_s1", V_STALL, 8);
    idle(); dcache_miss = 1'b1;
    for (int i = 0; i < 4; i++) cyc("frz_hold", V_FREEZE, 9 + i);
    idle(); cyc("frz_br_s2", V_STALL, 13);
    cyc("frz_done", V_RUN, 14);

    dcache_miss = 1'b1; cyc("frz_run", V_FREEZE, 14);
    idle(); cyc("frz_run_done", V_RUN, 15);

    if_id_halt = 1'b1; cyc("hlt_detect", V_BUBBLE, 15);
    idle();
    for (int i = 0; i < 3; i++) cyc("drain", V_BUBBLE, 16 + i);
    cyc("halted", V_HALTED, 19);
    dcache_miss = 1'b1; cyc("halted_dmiss", V_HALTED, 19);
    idle(); branch_taken = 1'b1; cyc("halted_taken", V_HALTED, 19);
    idle(); rst_cyc();
    cyc("post_rst_run", V_RUN, 0);

    ex_load(4'd2); if_id_br_reg = 1'b1; if_id_rs = 4'd2;
    cyc("rst_stall_s1", V_STALL, 0);
    idle(); rst_cyc();
    cyc("rst_mid_stall", V_RUN, 0);

    if_id_halt = 1'b1; cyc("rst_hlt", V_BUBBLE, 0);
    idle(); cyc("rst_drain1", V_BUBBLE, 1);
    rst_cyc();
    cyc("rst_mid_drain", V_RUN, 0);

    dcache_miss = 1'b1;
    for (int i = 0; i < 34; i++) cyc("saturate", V_FREEZE, (i > 31) ? 31 : i);
    idle(); cyc("saturate_hold", V_RUN, 31);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
